gfe_inv_seq: RTL

Iterative GF(2^m) inverter for the systolic Gaussian-elimination array. It sits directly upstream of the elimination cells' inverse inputs and supplies the pivot inverse (dout) and the pivot-nonzero flag (dout_nz). These feed the cell's inv_in / inv_en pair. Inversion uses Fermat's method, a^(2^m-2) = product of a^(2^i) for i = 1..m-1, with one square and one multiply per cycle, behind a valid/ready handshake.

---
 rtl/gfe_inv_seq_if.sv | 23 ++
 rtl/gfe_inv_seq.sv | 91 +++++++++
 2 files changed

// File: rtl/gfe_inv_seq_if.sv
// rtl/gfe_inv_seq_if.sv - operand/result handshake bundle for the GF(2^m) inverter
// The slave side is the inverter; the master side is the operand producer / result consumer.
interface gfe_inv_seq_if #(
  parameter int WIDTH = 13
);
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] din;
  logic             dout_valid;
  logic             dout_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_nz;

  modport master (
    output din_valid, din, dout_ready,
    input  din_ready, dout_valid, dout, dout_nz
  );

  modport slave (
    input  din_valid, din, dout_ready,
    output din_ready, dout_valid, dout, dout_nz
  );
endinterface

// File: rtl/gfe_inv_seq.sv
// rtl/gfe_inv_seq.sv - iterative Fermat GF(2^m) inverter, one square and one multiply per cycle
// Result a^(2^m-2) is accumulated as the product of a^(2^i), i = 1..m-1.
module gfe_inv_seq #(
  parameter int               WIDTH = 13,
  parameter logic [WIDTH-1:0] POLY  = 13'h001B
) (
  input  logic          clk,
  input  logic          rst,
  gfe_inv_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sq_q, sq_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             nz_q, nz_d;
  logic [WIDTH-1:0] sq_next;
  logic [WIDTH-1:0] res_next;

  // MSB-first shift-and-add; each shift folds x^WIDTH back in as POLY.
  function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      r = {r[WIDTH-2:0], 1'b0} ^ (r[WIDTH-1] ? POLY : '0);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  assign sq_next  = gf_mul(sq_q, sq_q);
  assign res_next = gf_mul(res_q, sq_next);

  always_comb begin
    state_d = state_q;
    sq_d    = sq_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    nz_d    = nz_q;
    case (state_q)
      IDLE: begin
        if (bus.din_valid) begin
          sq_d    = bus.din;
          res_d   = WIDTH'(1);
          cnt_d   = CW'(WIDTH - 1);
          nz_d    = |bus.din;
          state_d = RUN;
        end
      end
      RUN: begin
        sq_d  = sq_next;
        res_d = res_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.dout_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sq_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      nz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sq_q    <= sq_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      nz_q    <= nz_d;
    end
  end

  assign bus.din_ready  = (state_q == IDLE);
  assign bus.dout_valid = (state_q == DONE);
  assign bus.dout       = res_q;
  assign bus.dout_nz    = nz_q;

endmodule
